// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmit framer.
//
// Takes one byte per tx_valid/tx_ready handshake and shifts it out LSB-first
// as: start bit (0), DATA_BITS data bits, optional even parity bit, one stop
// bit (1). Every bit lasts CLKS_PER_BIT system clocks, timed by an internal
// cycle counter. The line output is registered and idles high.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (PARITY state + flop).
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..8)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; aborts any frame in flight
//   tx_data     byte to send, sampled only on the accept cycle
//   tx_valid    producer offers tx_data
//   tx_ready    high while idle; accept = tx_valid && tx_ready
//   serial_out  UART line, registered, idles high
//   tx_busy     high while a frame is in flight
//   tx_done     one-cycle pulse in the first idle cycle after the stop bit
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [CYC_W-1:0]     cyc_cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_next;
    logic                 serial_next;
    logic                 done_next;
    logic                 accept;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
    logic                 par_next;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // tx_ready depends only on state, so accept has no path back into tx_ready.
    assign accept  = tx_valid && (state == S_IDLE);
    assign bit_end = (cyc_cnt == CYC_LAST);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept)  state_next = S_START;
            S_START:  if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_next = S_STOP;
`endif
            S_STOP:   if (bit_end) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Counter / shift-register update. The cycle counter is held at 0 in
    // IDLE and cleared on every bit boundary.
    always_comb begin
        cyc_cnt_next = cyc_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_q;
`ifdef UART_TX_PARITY_EN
        par_next     = par_q;
`endif
        if (state == S_IDLE) begin
            cyc_cnt_next = '0;
            bit_cnt_next = '0;
            if (accept) begin
                shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
                par_next   = even_parity(tx_data);
`endif
            end
        end else if (bit_end) begin
            cyc_cnt_next = '0;
            if (state == S_DATA) begin
                shift_next   = shift_q >> 1;
                bit_cnt_next = bit_cnt + BIT_W'(1);
            end
        end else begin
            cyc_cnt_next = cyc_cnt + CYC_W'(1);
        end
    end

    // Output logic. serial_out is registered, so its next value is decoded
    // from the next state; the line then changes on the same edge as state.
    always_comb begin
        tx_ready    = (state == S_IDLE);
        tx_busy     = (state != S_IDLE);
        done_next   = (state == S_STOP) && (state_next == S_IDLE);
        serial_next = 1'b1;
        case (state_next)
            S_START:  serial_next = 1'b0;
            S_DATA:   serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_next = par_next;
`endif
            default:  serial_next = 1'b1;
        endcase
    end

    // State register (control, reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            cyc_cnt    <= cyc_cnt_next;
            bit_cnt    <= bit_cnt_next;
            serial_out <= serial_next;
            tx_done    <= done_next;
        end
    end

    // Data register (no reset; contents only matter after an accept)
    always_ff @(posedge clk) begin
        shift_q <= shift_next;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_next;
`endif
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame. A reference model (posedge process) decides
// from the bench's own inputs when a byte is accepted and queues the frame;
// a monitor (negedge process) compares the line, ready, busy and done
// against the queued frames every cycle and pops a frame when it completes.
module tb_uart_tx_frame;

    localparam int C = 4;
    localparam int D = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = D + 3;
`else
    localparam int NB = D + 2;
`endif
    localparam int FRAME = NB * C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [D-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic         serial_out;
    logic         tx_busy;
    logic         tx_done;

    uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
    endtask

    typedef struct {
        int           acc;
        logic [D-1:0] data;
    } frame_t;

    frame_t sb[$];
    int     free_at = 0;
    bit     armed = 0;

    // Bit k of the frame for byte d: start, data LSB-first, [parity], stop.
    function automatic logic frame_bit(input logic [D-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= D) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == D + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Reference model: accept/reset decisions from the bench's own inputs.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            free_at = cycle + 1;
            armed   = 1;
        end else if (armed && tx_valid && cycle >= free_at) begin
            sb.push_back('{acc: cycle, data: tx_data});
            free_at = cycle + FRAME + 1;
        end
    end

    // Monitor / scoreboard
    logic exp_line;
    bit   due;
    int   k;
    always @(negedge clk) begin
        if (armed) begin
            exp_line = 1'b1;
            due      = 0;
            if (sb.size() > 0) begin
                k = cycle - sb[0].acc - 1;
                if (k >= 0 && k < FRAME) exp_line = frame_bit(sb[0].data, k / C);
                due = (cycle == sb[0].acc + FRAME + 1);
            end
            check("serial_out", int'(serial_out), int'(exp_line));
            check("tx_ready", int'(tx_ready), int'(cycle >= free_at));
            check("tx_busy", int'(tx_busy), int'(cycle < free_at));
            check("tx_done", int'(tx_done), int'(due));
            if ((tx_done || due) && sb.size() > 0) void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer d and wait for the accept edge; optionally keep tx_valid high.
    task automatic send(input logic [D-1:0] d, input bit keep);
        bit acc = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !acc; i++) begin
            @(negedge clk);
            acc = tx_ready && !rst;
            @(posedge clk);
            #1;
        end
        if (!keep) tx_valid = 1'b0;
        check("accept_timeout", int'(acc), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 4 * FRAME) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Reset while idle
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single frames, including both parity polarities
        send(8'hA5, 0);
        wait_idle();
        send(8'h07, 0);
        wait_idle();

        // Back-to-back with tx_valid held
        send(8'h55, 1);
        tx_data = 8'hFF;
        send(8'hFF, 0);
        wait_idle();

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame
        send(8'h3C, 0);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_line_high", int'(serial_out), 1);
        check("abort_no_done", int'(tx_done), 0);
        tick();
        send(8'h81, 0);
        wait_idle();

        // tx_data toggling while busy
        send(8'($urandom), 0);
        for (int i = 0; i < FRAME; i++) begin
            tx_data = 8'($urandom);
            tick();
        end
        wait_idle();

        // Randomised traffic: held valid, data churn, gaps, occasional reset
        for (int it = 0; it < 40; it++) begin
            bit keep;
            int gap;
            keep = ($urandom_range(0, 3) == 0);
            send(8'($urandom), keep);
            gap = $urandom_range(0, FRAME + 3);
            for (int j = 0; j < gap; j++) begin
                tx_data = 8'($urandom);
                tick();
            end
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        tx_valid = 1'b0;
        wait_idle();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
